axi4_write_master: RTL

// - DMA write-side engine. Drains the 32-bit data FIFO filled by the read master and writes it to i_dst_addr as AXI4 INCR bursts.
// - Splits each transfer at C_MAX_BURST_BYTES and at 4KB boundaries.
// - Pulses o_write_done once the final B response is accepted.

---
 rtl/dma_pkg.sv | 21 ++
 rtl/dma_burst_calc.sv | 32 +++
 rtl/axi4_write_master.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI encodings, the 4KB boundary size and the
// write-master state encoding. Imported by both DMA masters.
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned BOUNDARY_4K   = 4096;

    // Write-master states, 3-bit encoding kept stable for existing debug tooling
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        AW   = 3'd2,
        W    = 3'd3,
        B    = 3'd4,
        DONE = 3'd5
    } wm_state_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: the next burst is the smallest of the bytes still to move,
// the configured maximum burst, and the bytes left before the next 4KB page.
// Purely combinational so both DMA masters can register the result as needed.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int unsigned C_MAX_BURST_BYTES = 64
) (
    input  logic [31:0] i_rem,
    input  logic [11:0] i_addr_low,
    output logic [12:0] o_bytes,
    output logic [7:0]  o_awlen
);

    logic [12:0] to_4k;
    logic [12:0] cap;
    logic [10:0] beats_m1;

    // Clamp against the page boundary first, then against the remaining length
    always_comb begin
        to_4k = 13'(BOUNDARY_4K) - {1'b0, i_addr_low};
        cap   = (to_4k < 13'(C_MAX_BURST_BYTES)) ? to_4k : 13'(C_MAX_BURST_BYTES);
        if (i_rem < {19'd0, cap}) begin
            o_bytes = i_rem[12:0];
        end else begin
            o_bytes = cap;
        end
        beats_m1 = o_bytes[12:2] - 11'd1;
        o_awlen  = beats_m1[7:0];
    end

endmodule

// File: rtl/axi4_write_master.sv
// DMA write-side engine. Pulls 32-bit words from a first-word-fall-through
// FIFO and writes them to memory as AXI4 INCR bursts, one burst outstanding
// at a time, split at the maximum burst size and at 4KB pages.
module axi4_write_master
    import dma_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_BYTES  = 64
) (
    input  logic                              clk,
    input  logic                              reset_n,

    input  logic                              i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_dst_addr,
    input  logic [31:0]                       i_total_len,
    output logic                              o_write_done,
    output logic                              o_write_err,

    input  logic                              i_fifo_empty,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_fifo_data,
    output logic                              o_fifo_pop,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,

    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready
);

    wm_state_t                         state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [31:0]                       rem_q, rem_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [7:0]                        awlen_q, awlen_d;
    logic [12:0]                       bytes_q, bytes_d;
    logic [7:0]                        beat_q, beat_d;
    logic                              err_q, err_d;

    logic [12:0]                       calc_bytes;
    logic [7:0]                        calc_awlen;
    logic                              w_hs;

    dma_burst_calc #(
        .C_MAX_BURST_BYTES (C_MAX_BURST_BYTES)
    ) u_burst_calc (
        .i_rem      (rem_q),
        .i_addr_low (addr_q[11:0]),
        .o_bytes    (calc_bytes),
        .o_awlen    (calc_awlen)
    );

    assign w_hs = (state_q == W) && !i_fifo_empty && m_axi_wready;

    // Next-state and datapath updates for the burst sequencer
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        bytes_d  = bytes_q;
        beat_d   = beat_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d  = i_dst_addr & ~C_M_AXI_ADDR_WIDTH'(3);
                    rem_d   = i_total_len & ~32'd3;
                    err_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (rem_q == 32'd0) begin
                    state_d = DONE;
                end else begin
                    awaddr_d = addr_q;
                    awlen_d  = calc_awlen;
                    bytes_d  = calc_bytes;
                    state_d  = AW;
                end
            end
            AW: begin
                if (m_axi_awready) begin
                    addr_d  = addr_q + C_M_AXI_ADDR_WIDTH'(bytes_q);
                    rem_d   = rem_q - 32'(bytes_q);
                    beat_d  = 8'd0;
                    state_d = W;
                end
            end
            W: begin
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == awlen_q) begin
                        state_d = B;
                    end
                end
            end
            B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = (rem_q != 32'd0) ? CALC : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer in flight without a done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            bytes_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            bytes_q  <= bytes_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = (state_q == AW);

    assign m_axi_wvalid  = (state_q == W) && !i_fifo_empty;
    assign m_axi_wdata   = (state_q == W) ? i_fifo_data : '0;
    assign m_axi_wstrb   = (state_q == W) ? {(C_M_AXI_DATA_WIDTH/8){1'b1}} : '0;
    assign m_axi_wlast   = (state_q == W) && (beat_q == awlen_q);
    assign o_fifo_pop    = w_hs;

    assign m_axi_bready  = (state_q == B);

    assign o_write_done  = (state_q == DONE);
    assign o_write_err   = err_q;

endmodule
